ws2812_pattern_gen: RTL and testbench

Parametrised pixel-colour generator that feeds the WS2812 serialiser. It replaces the fixed single-mode rainbow with four modes, a programmable per-frame phase step, a per-pixel hue spread and global brightness scaling. The serialiser requests one pixel at a time by index and signals frame completion. The block returns a 24-bit GRB word through a fixed 2-cycle pipeline.

---
 rtl/ws2812_pkg.sv | 35 +++
 rtl/ws2812_color_wheel.sv | 36 +++
 rtl/ws2812_pattern_gen.sv | 137 +++++++++++++
 tb/tb_ws2812_pattern_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 pixel-colour generator: GRB layout, modes,
// colour-wheel segment bounds and the brightness scaler.
package ws2812_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned GRB_W = 3 * CH_W;
  localparam int unsigned G_LSB = 0;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned B_LSB = 16;

  localparam logic [7:0] WHEEL_SEG1 = 8'd85;
  localparam logic [7:0] WHEEL_SEG2 = 8'd170;

  typedef enum logic [1:0] {
    MODE_RAINBOW = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // (c * (bright + 1)) >> 8 with a 16-bit product; bright 255 is the identity.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                               input logic [CH_W-1:0] bright);
    logic [15:0] prod;
    prod = 16'(c) * (16'(bright) + 16'd1);
    return CH_W'(prod >> 8);
  endfunction

endpackage

// File: rtl/ws2812_color_wheel.sv
// Combinational 8-bit colour wheel: red -> green -> blue -> red over 0..255.
module ws2812_color_wheel
  import ws2812_pkg::*;
(
  input  logic [7:0] wheel_i,
  output rgb_t       rgb_c
);

  logic [7:0] seg_off;
  logic [7:0] up;
  logic [7:0] down;

  always_comb begin
    seg_off = wheel_i;
    rgb_c   = '0;
    if (wheel_i >= WHEEL_SEG2) begin
      seg_off = wheel_i - WHEEL_SEG2;
    end else if (wheel_i >= WHEEL_SEG1) begin
      seg_off = wheel_i - WHEEL_SEG1;
    end
    // seg_off < 85, so 3*seg_off never exceeds 252
    up   = 8'(10'(seg_off) * 10'd3);
    down = 8'd255 - up;
    if (wheel_i < WHEEL_SEG1) begin
      rgb_c.r = down;
      rgb_c.g = up;
    end else if (wheel_i < WHEEL_SEG2) begin
      rgb_c.g = down;
      rgb_c.b = up;
    end else begin
      rgb_c.r = up;
      rgb_c.b = down;
    end
  end

endmodule

// File: rtl/ws2812_pattern_gen.sv
// Pixel-colour generator for the WS2812 serialiser: four modes, per-frame phase
// stepping and brightness, returning GRB through a fixed 2-stage pipeline.
module ws2812_pattern_gen
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_PIXELS  = 48,
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned HUE_SPREAD  = 5,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   px_req,
  input  logic [IDX_W-1:0]       px_idx,
  input  logic                   frame_tick,
  input  logic [1:0]             mode_in,
  input  logic [7:0]             step_in,
  input  logic [7:0]             bright_in,
  output logic                   px_valid,
  output logic [GRB_W-1:0]       pixel_color,
  output logic [7:0]             phase_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   px_oob
);

  // Frame-level state, only changed on frame_tick
  logic [7:0]             phase_q, phase_d;
  logic [IDX_W-1:0]       chase_q, chase_d;
  mode_e                  mode_q;
  logic [7:0]             step_q;
  logic [7:0]             bright_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Pipeline stage 1
  logic                   s1_valid_q;
  logic [7:0]             s1_wheel_q, s1_wheel_d;
  logic                   s1_black_q, s1_black_d;
  logic                   s1_oob_q, s1_oob_d;
  logic [7:0]             s1_bright_q;

  // Pipeline stage 2
  logic                   valid_q;
  logic [GRB_W-1:0]       color_q, color_d;
  logic                   oob_q;

  rgb_t                   wheel_rgb;

  always_comb begin
    phase_d = phase_q + step_q;
    chase_d = (chase_q == IDX_W'(NUM_PIXELS - 1)) ? '0 : chase_q + IDX_W'(1);
  end

  // Stage 1: wheel index and black decision from the frame's active settings
  always_comb begin
    s1_wheel_d = phase_q;
    s1_black_d = 1'b0;
    s1_oob_d   = (32'(px_idx) >= NUM_PIXELS);
    unique case (mode_q)
      MODE_RAINBOW: s1_wheel_d = 8'(16'(px_idx) * 16'(HUE_SPREAD)) + phase_q;
      MODE_SOLID:   s1_wheel_d = phase_q;
      MODE_CHASE:   s1_black_d = (px_idx != chase_q);
      MODE_OFF:     s1_black_d = 1'b1;
      default:      s1_black_d = 1'b1;
    endcase
    if (s1_oob_d) begin
      s1_black_d = 1'b1;
    end
  end

  ws2812_color_wheel u_wheel (
    .wheel_i (s1_wheel_q),
    .rgb_c   (wheel_rgb)
  );

  always_comb begin
    color_d = '0;
    if (!s1_black_q) begin
      color_d[G_LSB +: CH_W] = scale_ch(wheel_rgb.g, s1_bright_q);
      color_d[R_LSB +: CH_W] = scale_ch(wheel_rgb.r, s1_bright_q);
      color_d[B_LSB +: CH_W] = scale_ch(wheel_rgb.b, s1_bright_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      chase_q     <= '0;
      mode_q      <= MODE_RAINBOW;
      step_q      <= '0;
      bright_q    <= '0;
      frame_cnt_q <= '0;
    end else if (frame_tick) begin
      phase_q     <= phase_d;
      chase_q     <= chase_d;
      mode_q      <= mode_e'(mode_in);
      step_q      <= step_in;
      bright_q    <= bright_in;
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  // Brightness travels with the request so a tick mid-flight cannot affect it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_wheel_q  <= '0;
      s1_black_q  <= 1'b0;
      s1_oob_q    <= 1'b0;
      s1_bright_q <= '0;
      valid_q     <= 1'b0;
      color_q     <= '0;
      oob_q       <= 1'b0;
    end else begin
      s1_valid_q <= px_req;
      if (px_req) begin
        s1_wheel_q  <= s1_wheel_d;
        s1_black_q  <= s1_black_d;
        s1_oob_q    <= s1_oob_d;
        s1_bright_q <= bright_q;
      end
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        color_q <= color_d;
        if (s1_oob_q) begin
          oob_q <= 1'b1;
        end
      end
    end
  end

  assign px_valid    = valid_q;
  assign pixel_color = color_q;
  assign phase_out   = phase_q;
  assign frame_cnt   = frame_cnt_q;
  assign px_oob      = oob_q;

endmodule

// File: tb/tb_ws2812_pattern_gen.sv
// Directed bench for ws2812_pattern_gen with hand-computed expected colours.
module tb_ws2812_pattern_gen;

  logic        clk;
  logic        rst_n;
  logic        px_req;
  logic [5:0]  px_idx;
  logic        frame_tick;
  logic [1:0]  mode_in;
  logic [7:0]  step_in;
  logic [7:0]  bright_in;
  logic        px_valid;
  logic [23:0] pixel_color;
  logic [7:0]  phase_out;
  logic [15:0] frame_cnt;
  logic        px_oob;

  int vectors    = 0;
  int miscompares = 0;

  ws2812_pattern_gen #(
    .NUM_PIXELS  (48),
    .IDX_W       (6),
    .HUE_SPREAD  (5),
    .FRAME_CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .px_req      (px_req),
    .px_idx      (px_idx),
    .frame_tick  (frame_tick),
    .mode_in     (mode_in),
    .step_in     (step_in),
    .bright_in   (bright_in),
    .px_valid    (px_valid),
    .pixel_color (pixel_color),
    .phase_out   (phase_out),
    .frame_cnt   (frame_cnt),
    .px_oob      (px_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference wheel plus brightness, returned as GRB
  function automatic logic [23:0] model_grb(input int w, input int br);
    int r;
    int g;
    int b;
    if (w < 85) begin
      r = 255 - 3 * w; g = 3 * w; b = 0;
    end else if (w < 170) begin
      r = 0; g = 255 - 3 * (w - 85); b = 3 * (w - 85);
    end else begin
      r = 3 * (w - 170); g = 0; b = 255 - 3 * (w - 170);
    end
    r = (r * (br + 1)) / 256;
    g = (g * (br + 1)) / 256;
    b = (b * (br + 1)) / 256;
    return {8'(b), 8'(r), 8'(g)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [1:0] m, input logic [7:0] s, input logic [7:0] b);
    @(negedge clk);
    mode_in = m; step_in = s; bright_in = b; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic pixel(input int idx, input logic [23:0] exp, input string tag);
    @(negedge clk);
    px_req = 1'b1; px_idx = 6'(idx);
    @(negedge clk);
    px_req = 1'b0;
    check({tag, "_early"}, 32'(px_valid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, 32'(px_valid), 32'd1);
    check(tag, 32'(pixel_color), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; px_req = 1'b0; px_idx = '0; frame_tick = 1'b0;
    mode_in = 2'd0; step_in = 8'd0; bright_in = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(px_valid), 32'd0);
    check("rst_color", 32'(pixel_color), 32'd0);
    check("rst_phase", 32'(phase_out), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_oob", 32'(px_oob), 32'd0);
    rst_n = 1'b1;

    // Rainbow at full brightness, phase 0
    tick(2'd0, 8'd0, 8'd255);
    pixel(0, 24'h00FF00, "rb_idx0");
    pixel(17, 24'h0000FF, "rb_idx17");
    pixel(34, 24'hFF0000, "rb_idx34");

    // Brightness
    tick(2'd0, 8'd0, 8'd128);
    pixel(0, 24'h008000, "bright128");
    tick(2'd0, 8'd0, 8'd0);
    pixel(0, 24'h000000, "bright0");

    // Solid mode: first tick loads step 3, the next two advance phase to 6
    do_reset();
    tick(2'd1, 8'd3, 8'd255);
    check("solid_ph_first", 32'(phase_out), 32'd0);
    tick(2'd1, 8'd3, 8'd255);
    tick(2'd1, 8'd3, 8'd255);
    check("solid_phase", 32'(phase_out), 32'd6);
    check("solid_fcnt", 32'(frame_cnt), 32'd3);
    pixel(9, 24'h00ED12, "solid_idx9");
    pixel(40, 24'h00ED12, "solid_idx40");

    // Phase wrap 254 + 3 -> 1
    do_reset();
    tick(2'd1, 8'd127, 8'd255);
    tick(2'd1, 8'd127, 8'd255);
    tick(2'd1, 8'd3, 8'd255);
    check("wrap_254", 32'(phase_out), 32'd254);
    tick(2'd1, 8'd3, 8'd255);
    check("wrap_1", 32'(phase_out), 32'd1);

    // Chase: chase_pos tracks tick count modulo 48
    do_reset();
    for (int i = 0; i < 5; i++) tick(2'd2, 8'd0, 8'd255);
    pixel(5, 24'h00FF00, "chase_lit5");
    pixel(4, 24'h000000, "chase_dark4");
    pixel(6, 24'h000000, "chase_dark6");
    for (int i = 0; i < 43; i++) tick(2'd2, 8'd0, 8'd255);
    check("chase_fcnt48", 32'(frame_cnt), 32'd48);
    pixel(0, 24'h00FF00, "chase_wrap0");
    pixel(47, 24'h000000, "chase_dark47");

    // Back-to-back requests 0..47 in rainbow mode
    tick(2'd0, 8'd0, 8'd255);
    check("oob_before", 32'(px_oob), 32'd0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("burst_vld%0d", k - 2), 32'(px_valid), 32'd1);
        check($sformatf("burst_px%0d", k - 2), 32'(pixel_color),
              32'(model_grb(((k - 2) * 5) % 256, 255)));
      end
      px_req = (k < 48);
      px_idx = 6'(k);
    end
    @(negedge clk);
    check("burst_end", 32'(px_valid), 32'd0);

    // Out-of-range index
    pixel(50, 24'h000000, "oob_black");
    check("oob_set", 32'(px_oob), 32'd1);
    pixel(3, model_grb(15, 255), "oob_after_ok");
    check("oob_sticky", 32'(px_oob), 32'd1);

    // mode_in change without tick has no effect
    @(negedge clk);
    mode_in = 2'd1;
    pixel(17, 24'h0000FF, "midframe_mode");

    // Request coincident with tick sees pre-tick phase and mode
    tick(2'd1, 8'd10, 8'd255);
    @(negedge clk);
    px_req = 1'b1; px_idx = 6'd0; frame_tick = 1'b1;
    mode_in = 2'd3; step_in = 8'd10; bright_in = 8'd255;
    @(negedge clk);
    px_req = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    check("coinc_vld", 32'(px_valid), 32'd1);
    check("coinc_color", 32'(pixel_color), 32'h00FF00);
    check("coinc_phase", 32'(phase_out), 32'd10);
    pixel(0, 24'h000000, "off_mode");

    // Reset with a request in flight
    @(negedge clk);
    px_req = 1'b1; px_idx = 6'd0;
    @(negedge clk);
    px_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstf_valid", 32'(px_valid), 32'd0);
    check("rstf_color", 32'(pixel_color), 32'd0);
    check("rstf_phase", 32'(phase_out), 32'd0);
    check("rstf_fcnt", 32'(frame_cnt), 32'd0);
    check("rstf_oob", 32'(px_oob), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstf_novalid", 32'(px_valid), 32'd0);
    @(negedge clk);
    check("rstf_novalid2", 32'(px_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
